// File: rtl/vc_pmem_arbiter.sv
// Arbitrates the single physical-memory line port between L2 requests and
// victim-cache writebacks, with same-address forwarding and bounded writeback deferral.
module vc_pmem_arbiter #(
  parameter int MAX_DEFER = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         l2_read,
  input  logic         l2_write,
  input  logic [11:0]  l2_address,
  input  logic [127:0] l2_wdata,
  output logic [127:0] l2_rdata,
  output logic         l2_resp,
  input  logic         vc_wb_req,
  input  logic [11:0]  vc_wb_address,
  input  logic [127:0] vc_wb_data,
  output logic         vc_wb_ack,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         l2_pmem_busy
);

  typedef enum logic [2:0] {IDLE, L2_RD, L2_WR, VC_WR, DONE} state_t;

  localparam logic [2:0] DEFER_MAX = 3'(MAX_DEFER);

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_defer_cnt;
  logic [11:0]   r_addr;
  logic [127:0]  r_wdata;
  logic [127:0]  r_rdata;
  logic          r_served_vc;

  logic w_addr_eq;
  logic w_fwd_hit;
  logic w_wr_hazard;
  logic w_defer_full;
  logic w_l2_grant;
  logic w_vc_grant;
  logic w_fwd;

  assign w_addr_eq    = (l2_address == vc_wb_address);
  assign w_fwd_hit    = l2_read && vc_wb_req && w_addr_eq;
  assign w_wr_hazard  = l2_write && vc_wb_req && w_addr_eq;
  assign w_defer_full = (r_defer_cnt == DEFER_MAX);

  always_comb begin
    w_state_next = r_state;
    w_l2_grant   = 1'b0;
    w_vc_grant   = 1'b0;
    w_fwd        = 1'b0;
    case (r_state)
      IDLE: begin
        // Same-address hazards first: forward a read, drain the victim before a write.
        if (w_fwd_hit) begin
          w_state_next = DONE;
          w_l2_grant   = 1'b1;
          w_fwd        = 1'b1;
        end else if (w_wr_hazard || (vc_wb_req && w_defer_full)) begin
          w_state_next = VC_WR;
          w_vc_grant   = 1'b1;
        end else if (l2_read) begin
          w_state_next = L2_RD;
          w_l2_grant   = 1'b1;
        end else if (l2_write) begin
          w_state_next = L2_WR;
          w_l2_grant   = 1'b1;
        end else if (vc_wb_req) begin
          w_state_next = VC_WR;
          w_vc_grant   = 1'b1;
        end
      end
      L2_RD, L2_WR, VC_WR: begin
        if (pmem_resp) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_defer_cnt <= 3'd0;
      r_addr      <= 12'd0;
      r_wdata     <= 128'd0;
      r_rdata     <= 128'd0;
      r_served_vc <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_vc_grant) begin
        r_addr      <= vc_wb_address;
        r_wdata     <= vc_wb_data;
        r_served_vc <= 1'b1;
      end else if (w_l2_grant) begin
        r_served_vc <= 1'b0;
        if (w_fwd) begin
          r_rdata <= vc_wb_data;
        end else begin
          r_addr  <= l2_address;
          r_wdata <= l2_wdata;
        end
      end

      if (r_state == L2_RD && pmem_resp) r_rdata <= pmem_rdata;

      // Counts L2 wins over a waiting writeback; saturates so the force condition holds.
      if (w_vc_grant) begin
        r_defer_cnt <= 3'd0;
      end else if (r_state == IDLE && !vc_wb_req) begin
        r_defer_cnt <= 3'd0;
      end else if (w_l2_grant && vc_wb_req && !w_defer_full) begin
        r_defer_cnt <= r_defer_cnt + 3'd1;
      end
    end
  end

  assign pmem_read    = (r_state == L2_RD);
  assign pmem_write   = (r_state == L2_WR) || (r_state == VC_WR);
  assign pmem_address = {r_addr, 4'b0000};
  assign pmem_wdata   = r_wdata;
  assign l2_rdata     = r_rdata;
  assign l2_resp      = (r_state == DONE) && !r_served_vc;
  assign vc_wb_ack    = (r_state == DONE) && r_served_vc;
  assign l2_pmem_busy = (r_state != IDLE);

endmodule

// File: tb/tb_vc_pmem_arbiter.sv
// Directed bench for vc_pmem_arbiter: forwarding, write ordering, writeback
// deferral limit, mid-transaction reset and spurious memory responses.
module tb_vc_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         l2_read, l2_write;
  logic [11:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         vc_wb_req;
  logic [11:0]  vc_wb_address;
  logic [127:0] vc_wb_data;
  logic         vc_wb_ack;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         l2_pmem_busy;

  logic [127:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_pmem_arbiter #(.MAX_DEFER(4)) dut (
    .clk(clk), .reset(reset),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .vc_wb_req(vc_wb_req), .vc_wb_address(vc_wb_address), .vc_wb_data(vc_wb_data),
    .vc_wb_ack(vc_wb_ack),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .l2_pmem_busy(l2_pmem_busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for a strobe, answers after lat cycles and applies it to the bench memory.
  // Returns in the cycle after pmem_resp, i.e. the resp/ack cycle.
  task automatic serve(input int lat, output logic was_wr, output logic [11:0] a,
                       output logic [127:0] wd);
    int k = 0;
    while (!(pmem_read || pmem_write) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("serve_grant", 128'(pmem_read | pmem_write), 128'd1);
    was_wr = pmem_write;
    a      = pmem_address[15:4];
    wd     = pmem_wdata;
    repeat (lat - 1) @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = mem[a];
    if (was_wr) mem[a] = wd;
    @(negedge clk);
    pmem_resp  = 1'b0;
    $display("txn %s addr=%h wdata=%h", was_wr ? "WR" : "RD", a, wd);
  endtask

  logic         wr;
  logic [11:0]  a;
  logic [127:0] wd;
  int           grants;
  logic         got_vc;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {4{20'h0, i[11:0]}};
    mem[12'h123] = {16{8'hA5}};
    reset = 1'b1; l2_read = 0; l2_write = 0; l2_address = 0; l2_wdata = 0;
    vc_wb_req = 0; vc_wb_address = 0; vc_wb_data = 0; pmem_rdata = 0; pmem_resp = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_l2_resp",  128'(l2_resp), 128'd0);
    check_eq("rst_vc_ack",   128'(vc_wb_ack), 128'd0);
    check_eq("rst_pmem_rd",  128'(pmem_read), 128'd0);
    check_eq("rst_pmem_wr",  128'(pmem_write), 128'd0);
    check_eq("rst_pmem_adr", 128'(pmem_address), 128'd0);
    check_eq("rst_pmem_wd",  pmem_wdata, 128'd0);
    check_eq("rst_l2_rdata", l2_rdata, 128'd0);
    check_eq("rst_busy",     128'(l2_pmem_busy), 128'd0);

    // Single L2 read, 3-cycle memory
    l2_read = 1'b1; l2_address = 12'h123;
    @(negedge clk);
    check_eq("rd_strobe", 128'(pmem_read), 128'd1);
    check_eq("rd_addr",   128'(pmem_address), 128'h1230);
    check_eq("rd_busy",   128'(l2_pmem_busy), 128'd1);
    serve(3, wr, a, wd);
    l2_read = 1'b0;
    check_eq("rd_resp",   128'(l2_resp), 128'd1);
    check_eq("rd_strobe_low", 128'(pmem_read), 128'd0);
    check_eq("rd_data",   l2_rdata, {16{8'hA5}});
    check_eq("rd_busy_done", 128'(l2_pmem_busy), 128'd1);
    @(negedge clk);
    check_eq("rd_resp_once", 128'(l2_resp), 128'd0);
    check_eq("rd_idle",   128'(l2_pmem_busy), 128'd0);

    // Forward: L2 read hits pending victim line
    l2_read = 1'b1; l2_address = 12'h040;
    vc_wb_req = 1'b1; vc_wb_address = 12'h040; vc_wb_data = {8{16'hDEAD}};
    @(negedge clk);
    l2_read = 1'b0;
    check_eq("fwd_resp",  128'(l2_resp), 128'd1);
    check_eq("fwd_data",  l2_rdata, {8{16'hDEAD}});
    check_eq("fwd_nopmem", 128'(pmem_read | pmem_write), 128'd0);
    check_eq("fwd_noack", 128'(vc_wb_ack), 128'd0);
    serve(1, wr, a, wd);
    vc_wb_req = 1'b0;
    check_eq("fwd_wb_wr",   128'(wr), 128'd1);
    check_eq("fwd_wb_addr", 128'(a), 128'h040);
    check_eq("fwd_wb_ack",  128'(vc_wb_ack), 128'd1);
    check_eq("fwd_wb_nol2", 128'(l2_resp), 128'd0);
    @(negedge clk);
    check_eq("fwd_ack_once", 128'(vc_wb_ack), 128'd0);

    // Same-address write hazard: victim lands first, L2 write last
    l2_write = 1'b1; l2_address = 12'h0F0; l2_wdata = {4{32'h1111_2222}};
    vc_wb_req = 1'b1; vc_wb_address = 12'h0F0; vc_wb_data = {4{32'hBEEF_0001}};
    serve(1, wr, a, wd);
    vc_wb_req = 1'b0;
    check_eq("haz_first_data", wd, {4{32'hBEEF_0001}});
    check_eq("haz_first_ack",  128'(vc_wb_ack), 128'd1);
    serve(1, wr, a, wd);
    l2_write = 1'b0;
    check_eq("haz_second_data", wd, {4{32'h1111_2222}});
    check_eq("haz_second_resp", 128'(l2_resp), 128'd1);
    check_eq("haz_final_mem",   mem[12'h0F0], {4{32'h1111_2222}});

    // Deferral limit: 4 L2 grants, then forced writeback; twice to show the count clears
    l2_read = 1'b1; l2_address = 12'h300;
    vc_wb_req = 1'b1; vc_wb_address = 12'h200; vc_wb_data = {4{32'hC0DE_0000}};
    for (int r = 0; r < 2; r++) begin
      grants = 0; got_vc = 1'b0;
      for (int k = 0; k < 8 && !got_vc; k++) begin
        serve(1, wr, a, wd);
        if (wr) begin
          got_vc = 1'b1;
          check_eq("def_vc_addr", 128'(a), 128'(vc_wb_address));
          check_eq("def_vc_data", wd, vc_wb_data);
          check_eq("def_vc_ack",  128'(vc_wb_ack), 128'd1);
        end else begin
          grants++;
          check_eq("def_l2_addr", 128'(a), 128'(l2_address));
          check_eq("def_l2_data", l2_rdata, mem[l2_address]);
          l2_address = l2_address + 12'd1;
        end
      end
      check_eq("def_grants", 128'(grants), 128'd4);
      check_eq("def_forced", 128'(got_vc), 128'd1);
      if (r == 0) begin
        vc_wb_address = 12'h201; vc_wb_data = {4{32'hC0DE_0001}};
      end else begin
        vc_wb_req = 1'b0; l2_read = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("def_idle", 128'(l2_pmem_busy), 128'd0);

    // Reset while pmem_write is high, then a late pmem_resp
    vc_wb_req = 1'b1; vc_wb_address = 12'h055; vc_wb_data = {4{32'h5555_AAAA}};
    @(negedge clk);
    check_eq("rmid_wr_high", 128'(pmem_write), 128'd1);
    reset = 1'b1; vc_wb_req = 1'b0;
    @(negedge clk);
    reset = 1'b0; pmem_resp = 1'b1;
    check_eq("rmid_wr_low", 128'(pmem_write), 128'd0);
    check_eq("rmid_noack",  128'(vc_wb_ack), 128'd0);
    check_eq("rmid_busy",   128'(l2_pmem_busy), 128'd0);
    @(negedge clk);
    pmem_resp = 1'b0;
    check_eq("rmid_late_noack", 128'(vc_wb_ack), 128'd0);
    check_eq("rmid_late_nol2",  128'(l2_resp), 128'd0);
    check_eq("rmid_late_busy",  128'(l2_pmem_busy), 128'd0);
    check_eq("rmid_late_wr",    128'(pmem_write), 128'd0);
    check_eq("rmid_addr_clr",   128'(pmem_address), 128'd0);
    $display("txn RESET mid-write");

    // Spurious pmem_resp while idle
    pmem_resp = 1'b1; pmem_rdata = {128{1'b1}};
    @(negedge clk);
    pmem_resp = 1'b0;
    check_eq("spur_rdata", l2_rdata, 128'd0);
    check_eq("spur_resp",  128'(l2_resp), 128'd0);
    check_eq("spur_ack",   128'(vc_wb_ack), 128'd0);
    check_eq("spur_busy",  128'(l2_pmem_busy), 128'd0);
    @(negedge clk);
    check_eq("spur_rd", 128'(pmem_read | pmem_write), 128'd0);
    $display("txn SPURIOUS pmem_resp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
